// File: rtl/axi_bridge_pkg.sv
// Shared AXI bridge definitions: fixed AXI attribute constants for
// single-beat writes and the write-queue entry record.
// The entry fields are sized for the widest supported bus; narrower
// instances zero-extend on write and use only the low bits on read.
package axi_bridge_pkg;

   localparam int AXI_ADDR_MAX = 64;
   localparam int AXI_DATA_MAX = 128;
   localparam int AXI_STRB_MAX = AXI_DATA_MAX / 8;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
   localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
   localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
   localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

   typedef struct packed {
      logic [AXI_ADDR_MAX-1:0] addr;
      logic [1:0]              size;
      logic [AXI_STRB_MAX-1:0] strb;
      logic [AXI_DATA_MAX-1:0] data;
   } wr_entry_t;

   // Request size code (bytes = 2**size) widened to the AXI awsize field
   function automatic logic [2:0] axi_size(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage

// File: rtl/axi_wr_entry_ram.sv
// Write-queue entry storage: one write port (allocation) and two
// asynchronous read ports, one for the AW channel and one for W.
// Contents are deliberately not reset; validity is tracked by pointers.
module axi_wr_entry_ram
   import axi_bridge_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IDX_W-1:0] waddr,
   input  wr_entry_t        wentry,
   input  logic [IDX_W-1:0] raddr_aw,
   output wr_entry_t        rentry_aw,
   input  logic [IDX_W-1:0] raddr_w,
   output wr_entry_t        rentry_w
);

   wr_entry_t mem [DEPTH];

   // Capture a newly accepted request into its slot
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wentry;
      end
   end

   assign rentry_aw = mem[raddr_aw];
   assign rentry_w  = mem[raddr_w];

endmodule

// File: rtl/axi_wr_queue.sv
// In-order AXI single-beat write queue. CPU requests are buffered in a
// DEPTH-entry ring; AW and W issue independently from their own pointers,
// and B responses retire the head entry once both have completed.
// Optional feature: define AXI_WR_RAW_CHECK_EN to build the read-after-write
// hazard comparator behind chk_addr/chk_hit (otherwise chk_hit is 0).
module axi_wr_queue
   import axi_bridge_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int AXI_ID = 1
) (
   input  logic                clk,
   input  logic                resetn,
   // CPU request
   input  logic                req_valid,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W/8-1:0] req_strb,
   input  logic [DATA_W-1:0]   req_data,
   output logic                req_ready,
   // AW channel
   output logic [3:0]          awid,
   output logic [ADDR_W-1:0]   awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [1:0]          awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic                awvalid,
   input  logic                awready,
   // W channel
   output logic [3:0]          wid,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   // B channel
   input  logic [3:0]          bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   // Status
   output logic                wr_done,
   output logic                wr_err,
   output logic                idle,
   input  logic [ADDR_W-1:0]   chk_addr,
   output logic                chk_hit
);

   localparam int PTR_W = $clog2(DEPTH);

   // Pointers carry one wrap bit above the slot index
   logic [PTR_W:0] alloc_ptr, aw_ptr, w_ptr, free_ptr;
   logic [PTR_W:0] outstanding;

   logic      accept, aw_fire, w_fire, head_done, b_fire;
   wr_entry_t new_entry, aw_entry, w_entry;
   logic      unused_bits;

   assign req_ready = (outstanding < (PTR_W+1)'(DEPTH));
   assign idle      = (outstanding == '0);
   assign accept    = req_valid && req_ready;

   assign awvalid   = (aw_ptr != alloc_ptr);
   assign wvalid    = (w_ptr != alloc_ptr);
   assign aw_fire   = awvalid && awready;
   assign w_fire    = wvalid && wready;

   // AW and W both lie between free and alloc, so "past the head" means done
   assign head_done = (aw_ptr != free_ptr) && (w_ptr != free_ptr);
   assign b_fire    = bvalid && head_done;
   assign bready    = 1'b1;

   // Pack the incoming request into the wide storage record
   always_comb begin
      new_entry      = '0;
      new_entry.addr = AXI_ADDR_MAX'(req_addr);
      new_entry.size = req_size;
      new_entry.strb = AXI_STRB_MAX'(req_strb);
      new_entry.data = AXI_DATA_MAX'(req_data);
   end

   axi_wr_entry_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk       (clk),
      .we        (accept),
      .waddr     (alloc_ptr[PTR_W-1:0]),
      .wentry    (new_entry),
      .raddr_aw  (aw_ptr[PTR_W-1:0]),
      .rentry_aw (aw_entry),
      .raddr_w   (w_ptr[PTR_W-1:0]),
      .rentry_w  (w_entry)
   );

   assign awid    = 4'(AXI_ID);
   assign awaddr  = aw_entry.addr[ADDR_W-1:0];
   assign awlen   = AXI_LEN_SINGLE;
   assign awsize  = axi_size(aw_entry.size);
   assign awburst = AXI_BURST_INCR;
   assign awlock  = AXI_LOCK_NORMAL;
   assign awcache = AXI_CACHE_NONE;
   assign awprot  = AXI_PROT_NONE;

   assign wid     = 4'(AXI_ID);
   assign wdata   = w_entry.data[DATA_W-1:0];
   assign wstrb   = w_entry.strb[DATA_W/8-1:0];
   assign wlast   = 1'b1;

   // Fields read but not forwarded on a given channel, plus the ignored bid
   assign unused_bits = ^{aw_entry, w_entry, bid, chk_addr};

   // Advance each ring pointer on its own handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         alloc_ptr <= '0;
         aw_ptr    <= '0;
         w_ptr     <= '0;
         free_ptr  <= '0;
      end else begin
         if (accept)  alloc_ptr <= alloc_ptr + 1'b1;
         if (aw_fire) aw_ptr    <= aw_ptr + 1'b1;
         if (w_fire)  w_ptr     <= w_ptr + 1'b1;
         if (b_fire)  free_ptr  <= free_ptr + 1'b1;
      end
   end

   // Track allocated-but-not-freed entries; accept+free together cancel
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         outstanding <= '0;
      end else begin
         case ({accept, b_fire})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Report each retired write one cycle after its B handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_done <= 1'b0;
         wr_err  <= 1'b0;
      end else begin
         wr_done <= b_fire;
         wr_err  <= b_fire && (bresp != 2'b00);
      end
   end

   // A B response must only arrive for a head entry whose AW and W are done
   assert property (@(posedge clk) disable iff (!resetn) bvalid |-> head_done);

`ifdef AXI_WR_RAW_CHECK_EN
   logic [ADDR_W-3:0] word_addr [DEPTH];

   // Shadow copy of word addresses so every slot can be compared at once
   always_ff @(posedge clk) begin
      if (accept) begin
         word_addr[alloc_ptr[PTR_W-1:0]] <= req_addr[ADDR_W-1:2];
      end
   end

   // A slot is live when its distance from the head is below outstanding
   always_comb begin
      logic [PTR_W-1:0] offset;
      chk_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         offset = PTR_W'(i) - free_ptr[PTR_W-1:0];
         if (({1'b0, offset} < outstanding) && (word_addr[i] == chk_addr[ADDR_W-1:2])) begin
            chk_hit = 1'b1;
         end
      end
   end
`else
   assign chk_hit = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_queue.sv
// Directed self-checking bench for axi_wr_queue (DEPTH=4, 32-bit bus).
module tb_axi_wr_queue;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [3:0]  req_strb;
   logic [31:0] req_data;
   logic        req_ready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic        wr_done;
   logic        wr_err;
   logic        idle;
   logic [31:0] chk_addr;
   logic        chk_hit;

   int n_assert = 0;
   int n_fail   = 0;
   int acc      = 0;

`ifdef AXI_WR_RAW_CHECK_EN
   localparam logic EXP_HIT = 1'b1;
`else
   localparam logic EXP_HIT = 1'b0;
`endif

   axi_wr_queue #(
      .DEPTH  (4),
      .ADDR_W (32),
      .DATA_W (32),
      .AXI_ID (1)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_size  (req_size),
      .req_strb  (req_strb),
      .req_data  (req_data),
      .req_ready (req_ready),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awlock    (awlock),
      .awcache   (awcache),
      .awprot    (awprot),
      .awvalid   (awvalid),
      .awready   (awready),
      .wid       (wid),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .wr_done   (wr_done),
      .wr_err    (wr_err),
      .idle      (idle),
      .chk_addr  (chk_addr),
      .chk_hit   (chk_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

   // Land 1 time unit after the rising edge; inputs are driven here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs follow freshly driven inputs
   task automatic settle();
      #1;
   endtask

   task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d);
      req_valid = v;
      req_addr  = a;
      req_data  = d;
      req_size  = 2'd2;
      req_strb  = 4'hF;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] dv [3];
      dv[0] = 32'hA0A0_0001;
      dv[1] = 32'hB1B1_0002;
      dv[2] = 32'hC2C2_0003;

      resetn = 1'b0;
      set_req(1'b0, 32'h0, 32'h0);
      awready = 1'b0; wready = 1'b0;
      bid = 4'd0; bresp = 2'b00; bvalid = 1'b0;
      chk_addr = 32'h0;

      // Reset state
      tick(); tick();
      settle();
      `CHK("rst_req_ready", req_ready, 1'b1);
      `CHK("rst_idle", idle, 1'b1);
      `CHK("rst_awvalid", awvalid, 1'b0);
      `CHK("rst_wvalid", wvalid, 1'b0);
      `CHK("rst_wr_done", wr_done, 1'b0);
      `CHK("rst_wr_err", wr_err, 1'b0);
      `CHK("rst_chk_hit", chk_hit, 1'b0);
      `CHK("bready", bready, 1'b1);
      `CHK("const_aw", {awid, awlen, awburst, awlock, awcache, awprot}, {4'd1, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      `CHK("const_w", {wid, wlast}, {4'd1, 1'b1});
      tick();
      resetn = 1'b1;

      // Single write to 0x1000
      set_req(1'b1, 32'h1000, 32'hDEAD_BEEF);
      awready = 1'b1; wready = 1'b1;
      settle();
      `CHK("t1_ready", req_ready, 1'b1);
      `CHK("t1_aw_before", awvalid, 1'b0);
      tick();
      req_valid = 1'b0;
      settle();
      `CHK("t1_awvalid", awvalid, 1'b1);
      `CHK("t1_wvalid", wvalid, 1'b1);
      `CHK("t1_awaddr", awaddr, 32'h1000);
      `CHK("t1_awsize", awsize, 3'b010);
      `CHK("t1_wdata", wdata, 32'hDEAD_BEEF);
      `CHK("t1_wstrb", wstrb, 4'hF);
      `CHK("t1_busy", idle, 1'b0);
      tick();
      settle();
      `CHK("t1_aw_done", awvalid, 1'b0);
      `CHK("t1_w_done", wvalid, 1'b0);
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bvalid = 1'b0;
      settle();
      `CHK("t1_wr_done", wr_done, 1'b1);
      `CHK("t1_wr_err", wr_err, 1'b0);
      `CHK("t1_idle", idle, 1'b1);
      tick();
      settle();
      `CHK("t1_done_pulse", wr_done, 1'b0);

      // Five back-to-back requests into a 4-deep queue with AW stalled
      awready = 1'b0; wready = 1'b0;
      acc = 0;
      for (int k = 0; k < 5; k++) begin
         set_req(1'b1, 32'h100 + 32'(4*k), 32'h5000 + 32'(k));
         settle();
         `CHK("t2_ready", req_ready, (k < 4));
         if (req_valid && req_ready) acc++;
         tick();
      end
      settle();
      `CHK("t2_still_full", req_ready, 1'b0);
      tick();
      req_valid = 1'b0;
      `CHK("t2_accepted", acc, 4);
      settle();
      `CHK("t2_awaddr0", awaddr, 32'h100);
      awready = 1'b1; wready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         n_assert++;
         if (awaddr !== (32'h100 + 32'(4*i))) begin
            n_fail++;
            $error("FAIL t2_aw_order: observed %0h, expected %0h", awaddr, 32'h100 + 32'(4*i));
         end
         n_assert++;
         if (wdata !== (32'h5000 + 32'(i))) begin
            n_fail++;
            $error("FAIL t2_wdata_order: observed %0h, expected %0h", wdata, 32'h5000 + 32'(i));
         end
         tick();
      end
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bvalid = 1'b0;
      settle();
      `CHK("t2_idle", idle, 1'b1);

      // W leads AW by three entries
      awready = 1'b0; wready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_req(1'b1, 32'h300 + 32'(4*k), dv[k]);
         settle();
         if (k > 0) begin
            `CHK("t3_wvalid", wvalid, 1'b1);
            `CHK("t3_wdata", wdata, dv[k-1]);
         end
         tick();
      end
      req_valid = 1'b0;
      settle();
      `CHK("t3_wdata_last", wdata, dv[2]);
      `CHK("t3_aw_waiting", awvalid, 1'b1);
      `CHK("t3_awaddr_head", awaddr, 32'h300);
      tick();
      settle();
      `CHK("t3_w_lead_done", wvalid, 1'b0);
      `CHK("t3_aw_pending", awvalid, 1'b1);
      awready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         n_assert++;
         if (awaddr !== (32'h300 + 32'(4*i))) begin
            n_fail++;
            $error("FAIL t3_aw_order: observed %0h, expected %0h", awaddr, 32'h300 + 32'(4*i));
         end
         tick();
      end
      awready = 1'b0;
      settle();
      `CHK("t3_aw_drained", awvalid, 1'b0);
      bvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) bvalid = 1'b0;
         settle();
         `CHK("t3_retire", wr_done, 1'b1);
      end
      `CHK("t3_idle", idle, 1'b1);

      // Full queue: B in the same cycle as a new request does not bypass
      awready = 1'b1; wready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_req(1'b1, 32'h400 + 32'(4*k), 32'h0);
         tick();
      end
      req_valid = 1'b0;
      tick();
      set_req(1'b1, 32'h4F0, 32'h1234_5678);
      bvalid = 1'b1;
      settle();
      `CHK("t4_no_bypass", req_ready, 1'b0);
      tick();
      bvalid = 1'b0;
      settle();
      `CHK("t4_ready_next", req_ready, 1'b1);
      `CHK("t4_wr_done", wr_done, 1'b1);
      tick();
      req_valid = 1'b0;
      settle();
      `CHK("t4_full_again", req_ready, 1'b0);
      `CHK("t4_new_awaddr", awaddr, 32'h4F0);
      `CHK("t4_new_wdata", wdata, 32'h1234_5678);
      tick();
      bvalid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      bvalid = 1'b0;
      settle();
      `CHK("t4_idle", idle, 1'b1);

      // Error response on the second of two writes
      set_req(1'b1, 32'h600, 32'h1);
      tick();
      set_req(1'b1, 32'h604, 32'h2);
      tick();
      req_valid = 1'b0;
      tick();
      bvalid = 1'b1; bresp = 2'b00;
      tick();
      bresp = 2'b10;
      settle();
      `CHK("t5_done1", wr_done, 1'b1);
      `CHK("t5_err1", wr_err, 1'b0);
      tick();
      bvalid = 1'b0; bresp = 2'b00;
      settle();
      `CHK("t5_done2", wr_done, 1'b1);
      `CHK("t5_err2", wr_err, 1'b1);
      tick();
      settle();
      `CHK("t5_err_clear", wr_err, 1'b0);
      `CHK("t5_idle", idle, 1'b1);

      // Read-after-write hazard comparator
      chk_addr = 32'h2006;
      set_req(1'b1, 32'h2004, 32'h77);
      settle();
      `CHK("t6_hit_before", chk_hit, 1'b0);
      tick();
      req_valid = 1'b0;
      settle();
      `CHK("t6_hit", chk_hit, EXP_HIT);
      chk_addr = 32'h3006;
      settle();
      `CHK("t6_other_word", chk_hit, 1'b0);
      chk_addr = 32'h2006;
      tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      settle();
      `CHK("t6_hit_freed", chk_hit, 1'b0);

      // Reset with two entries in flight
      awready = 1'b0; wready = 1'b0;
      set_req(1'b1, 32'h700, 32'h1);
      tick();
      set_req(1'b1, 32'h704, 32'h2);
      tick();
      req_valid = 1'b0;
      settle();
      `CHK("t7_pending", awvalid, 1'b1);
      `CHK("t7_busy", idle, 1'b0);
      resetn = 1'b0;
      settle();
      `CHK("t7_aw_drop", awvalid, 1'b0);
      `CHK("t7_w_drop", wvalid, 1'b0);
      `CHK("t7_idle", idle, 1'b1);
      `CHK("t7_ready", req_ready, 1'b1);
      tick();
      resetn = 1'b1;
      awready = 1'b1; wready = 1'b1;
      tick();
      settle();
      `CHK("t7_no_aw", awvalid, 1'b0);
      `CHK("t7_no_done", wr_done, 1'b0);
      `CHK("t7_idle_after", idle, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
